// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: word RAM behind a req/gnt/rvalid bus with fixed
// response latency, bounded outstanding requests and a side load port.
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter string       INIT_FILE       = "",
  localparam int         OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          load_we_i,
  input  logic [31:0]   load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic          load_err_o,
  output logic [OW-1:0] outstanding_o
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  // 33-bit upper compare so a window ending at 2^32 never wraps
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   fetch_off, load_off;
  logic [AW-1:0] fetch_idx, load_idx;
  logic          fetch_ok, load_ok;
  logic          unused_bits;

  assign fetch_off = instr_addr_i - BASE_ADDR;
  assign load_off  = load_addr_i - BASE_ADDR;
  assign fetch_idx = fetch_off[AW+1:2];
  assign load_idx  = load_off[AW+1:2];
  assign fetch_ok  = in_range(instr_addr_i);
  assign load_ok   = in_range(load_addr_i);
  assign unused_bits = ^{fetch_off[31:AW+2], fetch_off[1:0],
                         load_off[31:AW+2], load_off[1:0], (INIT_FILE != "")};

  // Reset release is synchronised so no grant races the deasserting edge
  logic [1:0] rst_sync;
  logic       rstn_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rstn_sync = rst_sync[1];

  // A response retiring this cycle frees its slot for a same-cycle grant
  assign instr_gnt_o = instr_req_i & rstn_sync &
                       ((outstanding_o < OW'(MAX_OUTSTANDING)) | instr_rvalid_o);

  logic [LATENCY:1]       vld_pipe;
  logic [LATENCY:1]       err_pipe;
  logic [LATENCY:1][31:0] dat_pipe;

  // Payload only advances with a valid, so the last stage holds its value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= instr_gnt_o;
      if (instr_gnt_o) begin
        err_pipe[1] <= !fetch_ok;
        dat_pipe[1] <= fetch_ok ? mem[fetch_idx] : 32'h0;
      end
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) begin
          err_pipe[i] <= err_pipe[i-1];
          dat_pipe[i] <= dat_pipe[i-1];
        end
      end
    end
  end

  assign instr_rvalid_o = vld_pipe[LATENCY];
  assign instr_err_o    = err_pipe[LATENCY];
  assign instr_rdata_o  = dat_pipe[LATENCY];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding_o <= '0;
      load_err_o    <= 1'b0;
    end else begin
      case ({instr_gnt_o, instr_rvalid_o})
        2'b10:   outstanding_o <= outstanding_o + OW'(1);
        2'b01:   outstanding_o <= outstanding_o - OW'(1);
        default: outstanding_o <= outstanding_o;
      endcase
      if (load_we_i && !load_ok) load_err_o <= 1'b1;
    end
  end

  // Nonblocking write: a same-cycle fetch of this word sees the old data
  always_ff @(posedge clk) begin
    if (load_we_i && load_ok) mem[load_idx] <= load_wdata_i;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: a LATENCY=1 instance driven from a vector table and a
// LATENCY=3 / MAX_OUTSTANDING=2 instance driven by hand-written sequences.
module tb_instr_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: BASE 0, 16 words, LATENCY 1, MAX 1
  logic        rstn_a, req_a, gnt_a, rvalid_a, err_a, we_a, lerr_a;
  logic [31:0] addr_a, rdata_a, laddr_a, lwdata_a;
  logic [0:0]  out_a;

  // instance B: BASE 0x1000, 16 words, LATENCY 3, MAX 2
  logic        rstn_b, req_b, gnt_b, rvalid_b, err_b, we_b, lerr_b;
  logic [31:0] addr_b, rdata_b, laddr_b, lwdata_b;
  logic [1:0]  out_b;

  instr_mem_responder #(.BASE_ADDR(32'h0), .DEPTH_WORDS(16), .LATENCY(1),
                        .MAX_OUTSTANDING(1), .INIT_FILE("")) u_a (
    .clk(clk), .rstn(rstn_a), .instr_req_i(req_a), .instr_addr_i(addr_a),
    .instr_gnt_o(gnt_a), .instr_rvalid_o(rvalid_a), .instr_rdata_o(rdata_a),
    .instr_err_o(err_a), .load_we_i(we_a), .load_addr_i(laddr_a),
    .load_wdata_i(lwdata_a), .load_err_o(lerr_a), .outstanding_o(out_a));

  instr_mem_responder #(.BASE_ADDR(32'h1000), .DEPTH_WORDS(16), .LATENCY(3),
                        .MAX_OUTSTANDING(2), .INIT_FILE("")) u_b (
    .clk(clk), .rstn(rstn_b), .instr_req_i(req_b), .instr_addr_i(addr_b),
    .instr_gnt_o(gnt_b), .instr_rvalid_o(rvalid_b), .instr_rdata_o(rdata_b),
    .instr_err_o(err_b), .load_we_i(we_b), .load_addr_i(laddr_b),
    .load_wdata_i(lwdata_b), .load_err_o(lerr_b), .outstanding_o(out_b));

  typedef struct {
    logic        we;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        lerr;
    logic        outst;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic we, logic [31:0] la, logic [31:0] lw,
                              logic rq, logic [31:0] ad, logic g, logic rv,
                              logic [31:0] rd, logic er, logic le, logic os);
    vec_t v;
    v.we = we; v.laddr = la; v.lwdata = lw; v.req = rq; v.addr = ad;
    v.gnt = g; v.rvalid = rv; v.rdata = rd; v.err = er; v.lerr = le; v.outst = os;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string nm, input logic g, input logic rv,
                       input logic [31:0] rd, input logic er, input logic [1:0] os);
    chk({nm, "_gnt"},    32'(gnt_b),    32'(g));
    chk({nm, "_rvalid"}, 32'(rvalid_b), 32'(rv));
    chk({nm, "_rdata"},  rdata_b,       rd);
    chk({nm, "_err"},    32'(err_b),    32'(er));
    chk({nm, "_outst"},  32'(out_b),    32'(os));
  endtask

  initial begin
    // load phase, then fetches; expectations are for the cycle after the vector
    vecs[0]  = mk(1, 32'h0,        32'h00000013, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 32'h4,        32'h00A00093, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0);
    vecs[2]  = mk(1, 32'h8,        32'h11111111, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0);
    vecs[3]  = mk(1, 32'h3C,       32'h22222222, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0);
    vecs[4]  = mk(0, 32'h0,        32'h0,        1, 32'h0,        1, 1, 32'h00000013, 0, 0, 1);
    vecs[5]  = mk(0, 32'h0,        32'h0,        1, 32'h4,        1, 1, 32'h00A00093, 0, 0, 1);
    vecs[6]  = mk(0, 32'h0,        32'h0,        1, 32'h6,        1, 1, 32'h00A00093, 0, 0, 1);
    vecs[7]  = mk(0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h00A00093, 0, 0, 0);
    vecs[8]  = mk(0, 32'h0,        32'h0,        1, 32'h40,       1, 1, 32'h0,        1, 0, 1);
    vecs[9]  = mk(0, 32'h0,        32'h0,        1, 32'hFFFFFFFC, 1, 1, 32'h0,        1, 0, 1);
    vecs[10] = mk(0, 32'h0,        32'h0,        1, 32'h3C,       1, 1, 32'h22222222, 0, 0, 1);
    vecs[11] = mk(1, 32'h8,        32'hDEADBEEF, 1, 32'h8,        1, 1, 32'h11111111, 0, 0, 1);
    vecs[12] = mk(0, 32'h0,        32'h0,        1, 32'h8,        1, 1, 32'hDEADBEEF, 0, 0, 1);
    vecs[13] = mk(1, 32'hFFFFFFFC, 32'h00000055, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 1, 0);
    vecs[14] = mk(1, 32'h40,       32'h00000066, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 1, 0);
    vecs[15] = mk(0, 32'h0,        32'h0,        1, 32'h3C,       1, 1, 32'h22222222, 0, 1, 1);
    vecs[16] = mk(0, 32'h0,        32'h0,        1, 32'h0,        1, 1, 32'h00000013, 0, 1, 1);

    rstn_a = 0; req_a = 0; addr_a = 0; we_a = 0; laddr_a = 0; lwdata_a = 0;
    rstn_b = 0; req_b = 0; addr_b = 0; we_b = 0; laddr_b = 0; lwdata_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_rvalid", 32'(rvalid_a), 32'h0);
    chk("rst_a_rdata",  rdata_a,       32'h0);
    chk("rst_a_err",    32'(err_a),    32'h0);
    chk("rst_a_lerr",   32'(lerr_a),   32'h0);
    chk("rst_a_outst",  32'(out_a),    32'h0);
    chk_b("rst_b", 0, 0, 32'h0, 0, 2'd0);
    rstn_a = 1; rstn_b = 1;
    repeat (3) tick();

    // ---- table-driven LATENCY=1 vectors ----
    for (int i = 0; i < 17; i++) begin
      we_a = vecs[i].we; laddr_a = vecs[i].laddr; lwdata_a = vecs[i].lwdata;
      req_a = vecs[i].req; addr_a = vecs[i].addr;
      #1;
      chk($sformatf("a%0d_gnt", i), 32'(gnt_a), 32'(vecs[i].gnt));
      tick();
      chk($sformatf("a%0d_rvalid", i), 32'(rvalid_a), 32'(vecs[i].rvalid));
      chk($sformatf("a%0d_rdata", i),  rdata_a,       vecs[i].rdata);
      chk($sformatf("a%0d_err", i),    32'(err_a),    32'(vecs[i].err));
      chk($sformatf("a%0d_lerr", i),   32'(lerr_a),   32'(vecs[i].lerr));
      chk($sformatf("a%0d_outst", i),  32'(out_a),    32'(vecs[i].outst));
    end
    we_a = 0; req_a = 0;

    // ---- B: load program words, one out-of-range load below base ----
    we_b = 1;
    laddr_b = 32'h1000; lwdata_b = 32'hA0; tick();
    laddr_b = 32'h1004; lwdata_b = 32'hA4; tick();
    laddr_b = 32'h1008; lwdata_b = 32'hA8; tick();
    chk("b_lerr_clean", 32'(lerr_b), 32'h0);
    laddr_b = 32'h0FFC; lwdata_b = 32'h77; tick();
    we_b = 0;
    chk("b_lerr_set", 32'(lerr_b), 32'h1);

    // ---- B: outstanding limit with req held over 0x1000,0x1004,0x1008 ----
    req_b = 1; addr_b = 32'h1000; #1; chk_b("b_c0", 1, 0, 32'h0, 0, 2'd0); tick();
    addr_b = 32'h1004;            #1; chk_b("b_c1", 1, 0, 32'h0, 0, 2'd1); tick();
    addr_b = 32'h1008;            #1; chk_b("b_c2", 0, 0, 32'h0, 0, 2'd2); tick();
    #1; chk_b("b_c3", 1, 1, 32'hA0, 0, 2'd2); tick();
    req_b = 0;
    #1; chk_b("b_c4", 0, 1, 32'hA4, 0, 2'd2); tick();
    #1; chk_b("b_c5", 0, 0, 32'hA4, 0, 2'd1); tick();
    #1; chk_b("b_c6", 0, 1, 32'hA8, 0, 2'd1); tick();
    #1; chk_b("b_c7", 0, 0, 32'hA8, 0, 2'd0);

    // ---- B: out-of-range fetches below base and at end of window ----
    req_b = 1; addr_b = 32'h0FFC; #1; chk("b_oor_lo_gnt", 32'(gnt_b), 32'h1); tick();
    addr_b = 32'h1040;            #1; chk("b_oor_hi_gnt", 32'(gnt_b), 32'h1); tick();
    req_b = 0; tick();
    #1; chk_b("b_oor_lo", 0, 1, 32'h0, 1, 2'd2); tick();
    #1; chk_b("b_oor_hi", 0, 1, 32'h0, 1, 2'd1); tick();
    #1; chk_b("b_oor_end", 0, 0, 32'h0, 1, 2'd0);

    // ---- B: reset with two responses in flight ----
    req_b = 1; addr_b = 32'h1008; #1; chk("b_rf0_gnt", 32'(gnt_b), 32'h1); tick();
    addr_b = 32'h1000;            #1; chk("b_rf1_gnt", 32'(gnt_b), 32'h1); tick();
    req_b = 0;
    rstn_b = 0;
    #1; chk_b("b_rst_in", 0, 0, 32'h0, 0, 2'd0);
    tick();
    rstn_b = 1;
    for (int i = 0; i < 5; i++) begin
      #1; chk_b($sformatf("b_post%0d", i), 0, 0, 32'h0, 0, 2'd0);
      tick();
    end
    req_b = 1; addr_b = 32'h1004; #1; chk("b_after_gnt", 32'(gnt_b), 32'h1); tick();
    req_b = 0; tick(); tick();
    #1; chk_b("b_after_rsp", 0, 1, 32'hA4, 0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
